spi_master: RTL
===============

Name: spi_master

Overview:
- Initiator end of the team's single-clock SPI link, driving SS_n/MOSI toward the SPI slave and sampling its MISO.
- Converts a 10-bit command word from the host side into one complete frame: a command bit, then 10 data bits MSB first.
- For read-data frames (word[9:8]=2'b11), also collects the 8-bit reply and returns it in parallel.
- SCLK is not generated; master and slave share clk, one bit per clock.

Parameters:
- RD_LATENCY, 3, edges from the edge that releases the last MOSI bit to the edge that samples the first MISO bit; legal range 1..15.
- GAP_CYCLES, 1, minimum cycles ss_n stays high between frames; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  frame request; accepted only when busy=0.
- tx_word  input  10  frame payload; latched when start is accepted.
- busy  output  1  high from the accepting edge until the gap completes.
- done  output  1  one-cycle pulse coinciding with the ss_n rise.
- rd_data  output  8  last received read byte; holds until the next read-data frame completes.
- rd_valid  output  1  one-cycle pulse with done, read-data frames only.
- SS_n  output  1  slave select, active-low, registered.
- MOSI  output  1  serial out, registered.
- MISO  input  1  serial in from the slave.

Behaviour:
- Reset values, effective immediately because reset is asynchronous: SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=8'h00, state=IDLE, all counters 0.
- Reset mid-frame aborts the frame: no done pulse, rd_data unchanged from its reset value.
- States: IDLE, SELECT, CMD, SHIFT, WAIT_RD, RECV, GUARD, GAP.
- Edge numbering: start is accepted at E0.
- IDLE: on start at E0, latch tx_word into shift_reg, SS_n<=0, busy<=1, go to SELECT.
- SELECT: at E1, MOSI<=tx_word[9] (the command bit), go to CMD.
- CMD: at E2, MOSI<=shift_reg[9], bit counter=1, go to SHIFT.
- SHIFT: at E2+k (k=1..9), MOSI<=shift_reg[9-k].
- Leaving SHIFT at E12:
  - MOSI<=0.
  - If word[9:8]==2'b11, go to WAIT_RD, else go to GUARD.
- WAIT_RD: counts RD_LATENCY-1 cycles, then goes to RECV.
- RECV:
  - Samples MISO at edges E(11+RD_LATENCY) .. E(18+RD_LATENCY), MSB first, into rx_shift.
  - After the 8th sample, load rd_data and go to GUARD.
  - The master reads MISO only in RECV; the slave's MISO is never interpreted outside that window.
- GUARD: one cycle with SS_n still low, so the slave's rx_valid window is observed.
  - On leaving: SS_n<=1, done<=1, rd_valid<=1 if the frame was read-data.
  - Go to GAP.
- GAP: holds SS_n=1 for GAP_CYCLES cycles, then busy<=0 and IDLE.
- Default timing: write / read-address frame SS_n low E0..E13, busy falls at E15.
- start while busy=1 is ignored and not queued. tx_word changes after acceptance have no effect.
- start in the same cycle busy falls is not accepted. The earliest next accept is the edge after busy is observed low.
- done and rd_valid are single-cycle pulses and never assert outside GUARD exit.
- Counters: 4-bit bit counter and 4-bit wait/gap counter; no wrap-around is possible within the legal parameter ranges.

Decomposition:
- Shared package spi_pkg:
  - State encoding localparams.
  - Opcode constants: OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
  - Frame constants: FRAME_BITS=10, RD_BITS=8.
- spi_slave also uses spi_pkg for the opcode constants.
- No sub-module: a single FSM with two shift registers and two counters.

Test Plan:
- Write-address: start with tx_word=10'h0A5 → SS_n low E0–E13; MOSI 0 at cycle E1, then bits 0010100101; done at E13; paired slave rx_data=10'h0A5 with rx_valid.
- Read-data: tx_word=10'h3FF with a slave+RAM model returning 8'hC3 → rd_data=8'hC3; rd_valid and done pulse together; SS_n rises at E22.
- Protocol gating: start pulsed at E5 during a frame with tx_word=10'h155 → ignored; first frame completes unchanged; no second frame.
- Async reset: rst asserted mid-SHIFT at E7 → SS_n=1 and MOSI=0 without a clock edge; no done; the next start after release yields a clean frame.
- Back-to-back: start held high through two frames (10'h001 then 10'h1FF) → SS_n high for at least 1 cycle between frames; the slave sees both words correctly.
- Parameter override: RD_LATENCY=5 against a slave model with 2 extra cycles of RAM delay, sending 8'h5A → rd_data=8'h5A.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the single-clock SPI link
// (spi_master and spi_slave).
package spi_pkg;

    localparam int FRAME_BITS = 10;
    localparam int RD_BITS    = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SELECT  = 3'd1;
    localparam logic [2:0] S_CMD     = 3'd2;
    localparam logic [2:0] S_SHIFT   = 3'd3;
    localparam logic [2:0] S_WAIT_RD = 3'd4;
    localparam logic [2:0] S_RECV    = 3'd5;
    localparam logic [2:0] S_GUARD   = 3'd6;
    localparam logic [2:0] S_GAP     = 3'd7;

    typedef enum logic [2:0] {
        IDLE    = S_IDLE,
        SELECT  = S_SELECT,
        CMD     = S_CMD,
        SHIFT   = S_SHIFT,
        WAIT_RD = S_WAIT_RD,
        RECV    = S_RECV,
        GUARD   = S_GUARD,
        GAP     = S_GAP
    } state_t;

endpackage

// File: rtl/spi_master.sv
// SPI initiator: sends a command bit plus a 10-bit word MSB first on a shared
// clock and, for read-data frames, collects the slave's 8-bit reply.
module spi_master
    import spi_pkg::*;
#(
    parameter int RD_LATENCY = 3,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] tx_word,
    output logic                  busy,
    output logic                  done,
    output logic [RD_BITS-1:0]    rd_data,
    output logic                  rd_valid,
    output logic                  SS_n,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam logic [3:0] LAST_BIT  = 4'(FRAME_BITS);
    localparam logic [3:0] RX_LAST   = 4'(RD_BITS - 1);
    localparam logic [3:0] WAIT_LAST = 4'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES);

    state_t                  state, state_n;
    logic [FRAME_BITS-1:0]   shift_reg, shift_n;
    logic [RD_BITS-1:0]      rx_shift, rx_n;
    logic [RD_BITS-1:0]      rd_data_n;
    logic [3:0]              bit_cnt, bit_cnt_n;
    logic [3:0]              wait_cnt, wait_cnt_n;
    logic                    is_rd, is_rd_n;
    logic                    busy_n, done_n, rd_valid_n, ss_n_n, mosi_n;

    // NOTE: every signal gets its hold/default value before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_n    = state;
        shift_n    = shift_reg;
        rx_n       = rx_shift;
        rd_data_n  = rd_data;
        bit_cnt_n  = bit_cnt;
        wait_cnt_n = wait_cnt;
        is_rd_n    = is_rd;
        busy_n     = busy;
        ss_n_n     = SS_n;
        mosi_n     = MOSI;
        done_n     = 1'b0;
        rd_valid_n = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    shift_n    = tx_word;
                    is_rd_n    = (tx_word[FRAME_BITS-1 -: 2] == OP_RD_DATA);
                    ss_n_n     = 1'b0;
                    busy_n     = 1'b1;
                    bit_cnt_n  = 4'd0;
                    wait_cnt_n = 4'd0;
                    state_n    = SELECT;
                end
            end
            SELECT: begin
                mosi_n  = shift_reg[FRAME_BITS-1];
                state_n = CMD;
            end
            CMD: begin
                mosi_n    = shift_reg[FRAME_BITS-1];
                shift_n   = {shift_reg[FRAME_BITS-2:0], 1'b0};
                bit_cnt_n = 4'd1;
                state_n   = SHIFT;
            end
            SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    mosi_n     = 1'b0;
                    bit_cnt_n  = 4'd0;
                    wait_cnt_n = 4'd0;
                    if (!is_rd) begin
                        state_n = GUARD;
                    end else if (RD_LATENCY == 1) begin
                        // Latency 1 puts the first MISO sample on this very edge.
                        rx_n      = {rx_shift[RD_BITS-2:0], MISO};
                        bit_cnt_n = 4'd1;
                        state_n   = RECV;
                    end else begin
                        state_n = WAIT_RD;
                    end
                end else begin
                    mosi_n    = shift_reg[FRAME_BITS-1];
                    shift_n   = {shift_reg[FRAME_BITS-2:0], 1'b0};
                    bit_cnt_n = bit_cnt + 4'd1;
                end
            end
            WAIT_RD: begin
                // The edge that leaves WAIT_RD already takes the first (MSB) sample.
                if (wait_cnt == WAIT_LAST) begin
                    rx_n      = {rx_shift[RD_BITS-2:0], MISO};
                    bit_cnt_n = 4'd1;
                    state_n   = RECV;
                end else begin
                    wait_cnt_n = wait_cnt + 4'd1;
                end
            end
            RECV: begin
                rx_n      = {rx_shift[RD_BITS-2:0], MISO};
                bit_cnt_n = bit_cnt + 4'd1;
                if (bit_cnt == RX_LAST) begin
                    rd_data_n = {rx_shift[RD_BITS-2:0], MISO};
                    bit_cnt_n = 4'd0;
                    state_n   = GUARD;
                end
            end
            GUARD: begin
                ss_n_n     = 1'b1;
                done_n     = 1'b1;
                rd_valid_n = is_rd;
                wait_cnt_n = 4'd0;
                state_n    = GAP;
            end
            GAP: begin
                if (wait_cnt == GAP_LAST) begin
                    busy_n     = 1'b0;
                    wait_cnt_n = 4'd0;
                    state_n    = IDLE;
                end else begin
                    wait_cnt_n = wait_cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            rx_shift  <= '0;
            rd_data   <= '0;
            bit_cnt   <= 4'd0;
            wait_cnt  <= 4'd0;
            is_rd     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            rx_shift  <= rx_n;
            rd_data   <= rd_data_n;
            bit_cnt   <= bit_cnt_n;
            wait_cnt  <= wait_cnt_n;
            is_rd     <= is_rd_n;
            busy      <= busy_n;
            done      <= done_n;
            rd_valid  <= rd_valid_n;
            SS_n      <= ss_n_n;
            MOSI      <= mosi_n;
        end
    end

endmodule
